// File: rtl/ssd_pkg.sv
// Shared widths and state encoding for the SSD source scheduler.
package ssd_pkg;

    localparam int N_SRC   = 4;
    localparam int SRC_W   = 2;
    localparam int DWELL_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around search: lowest set req index at or after start, modulo 4.
module rr_pick
    import ssd_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [SRC_W-1:0] start,
    output logic             found,
    output logic [SRC_W-1:0] idx
);

    logic [SRC_W-1:0] cand;

    // Scan farthest-first so the nearest hit to start is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = start + k[SRC_W-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ssd_source_scheduler.sv
// Round-robin scheduler picking which source word drives the 8-digit SSD.
module ssd_source_scheduler #(
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int          N_SRC        = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_SRC-1:0]   req,
    input  logic [N_SRC*32-1:0] data,
    input  logic               hold,
    input  logic               step,
    output logic [31:0]        dout,
    output logic [1:0]         cur_src,
    output logic               active
);

    import ssd_pkg::*;

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic               adv;
    logic [31:0]        word;

    // Search always starts one past the current source; reset value 3 makes the first pick start at 0.
    rr_pick u_pick (
        .req   (req),
        .start (cur_src + 2'd1),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Live word of the current source; registered into dout for one cycle of latency.
    assign word = data[{cur_src, 5'd0} +: 32];

    // Any of step, losing our own request, or unheld dwell expiry yields one single advance.
    assign adv = step | ~req[cur_src] | (~hold & (cnt == LAST));

    // Scheduler state, selection, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cur_src <= 2'd3;
            cnt     <= '0;
            dout    <= '0;
            active  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout <= '0;
                    if (pick_found) begin
                        state   <= SHOW;
                        active  <= 1'b1;
                        cur_src <= pick_idx;
                        cnt     <= '0;
                    end
                end
                SHOW: begin
                    if (req == '0) begin
                        state  <= IDLE;
                        active <= 1'b0;
                        dout   <= '0;
                        cnt    <= '0;
                    end else begin
                        dout <= word;
                        if (adv && pick_found) begin
                            // Lone requester re-picks itself, which just restarts the dwell.
                            cur_src <= pick_idx;
                            cnt     <= '0;
                        end else if (!hold && cnt != LAST) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_source_scheduler.sv
// Self-checking bench for ssd_source_scheduler with a 4-cycle dwell.
module tb_ssd_source_scheduler;

    localparam logic [31:0] D0 = 32'h11111111;
    localparam logic [31:0] D1 = 32'h55555555;
    localparam logic [31:0] D2 = 32'h22222222;
    localparam logic [31:0] D3 = 32'h33333333;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] data;
    logic         hold = 1'b0;
    logic         step = 1'b0;
    logic [31:0]  dout;
    logic [1:0]   cur_src;
    logic         active;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [1:0]  src;
        logic        act;
        logic [31:0] dout;
    } exp_t;

    typedef struct {
        logic [3:0]  r;
        logic        h;
        logic        s;
        logic [1:0]  es;
        logic        ea;
        logic [31:0] ed;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[17];

    ssd_source_scheduler #(.DWELL_CYCLES(4), .N_SRC(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .data    (data),
        .hold    (hold),
        .step    (step),
        .dout    (dout),
        .cur_src (cur_src),
        .active  (active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, wanted $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, wanted %h", name, act, exp);
    endtask

    // Drive one cycle at negedge, queue the expectation, compare at the next negedge.
    task automatic cyc(input logic [3:0] r, input logic h, input logic s,
                       input logic [1:0] es, input logic ea, input logic [31:0] ed);
        exp_t e;
        req = r; hold = h; step = s;
        sb.push_back('{src: es, act: ea, dout: ed});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("cur_src", {30'd0, cur_src}, {30'd0, e.src});
        chk("active", {31'd0, active}, {31'd0, e.act});
        chk("dout", dout, e.dout);
        step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = '0; hold = 1'b0; step = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        data = {D3, D2, D1, D0};

        // Basic rotation between 0 and 2, drop to idle, idle step, then own-request drop under hold.
        tbl[0]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        tbl[1]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0};
        tbl[2]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0};
        tbl[3]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0};
        tbl[4]  = '{4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, D0};
        tbl[5]  = '{4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, D2};
        tbl[6]  = '{4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, D2};
        tbl[7]  = '{4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, D2};
        tbl[8]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D2};
        tbl[9]  = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[11] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0};
        tbl[12] = '{4'b0011, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0};
        tbl[13] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, D1};
        tbl[14] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, D0};
        tbl[15] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, D0};
        tbl[16] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, D0};

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_cur_src", {30'd0, cur_src}, 32'd3);
        chk("rst_cnt", dut.cnt, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 17; i++)
            cyc(tbl[i].r, tbl[i].h, tbl[i].s, tbl[i].es, tbl[i].ea, tbl[i].ed);

        // Lone requester keeps the display across several dwell expiries.
        do_reset();
        cyc(4'b1000, 1'b0, 1'b0, 2'd3, 1'b1, 32'h0);
        for (int i = 0; i < 11; i++)
            cyc(4'b1000, 1'b0, 1'b0, 2'd3, 1'b1, D3);

        // Hold freezes the counter at 2; release needs two more cycles to advance.
        do_reset();
        cyc(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0);
        cyc(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0);
        cyc(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0);
        chk("hold_cnt_pre", dut.cnt, 32'd2);
        for (int i = 0; i < 10; i++)
            cyc(4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, D0);
        chk("hold_cnt_frozen", dut.cnt, 32'd2);
        cyc(4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, D0);
        chk("hold_cnt_resume", dut.cnt, 32'd3);
        cyc(4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, D0);
        chk("hold_cnt_adv", dut.cnt, 32'd0);

        // Step overrides hold.
        do_reset();
        cyc(4'b0110, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0);
        cyc(4'b0110, 1'b1, 1'b0, 2'd1, 1'b1, D1);
        cyc(4'b0110, 1'b1, 1'b1, 2'd2, 1'b1, D1);
        chk("step_cnt", dut.cnt, 32'd0);
        cyc(4'b0110, 1'b1, 1'b0, 2'd2, 1'b1, D2);

        // Step coinciding with own-request drop advances exactly once.
        do_reset();
        cyc(4'b0010, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0);
        cyc(4'b0011, 1'b0, 1'b0, 2'd1, 1'b1, D1);
        cyc(4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, D1);
        cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, D0);
        chk("single_adv_cnt", dut.cnt, 32'd1);

        // Reset mid-dwell aborts at once; restart picks source 2 fresh.
        do_reset();
        cyc(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0);
        cyc(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, D2);
        cyc(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, D2);
        rstn = 1'b0;
        #1;
        chk("midrst_dout", dout, 32'h0);
        chk("midrst_active", {31'd0, active}, 32'd0);
        chk("midrst_cur_src", {30'd0, cur_src}, 32'd3);
        @(negedge clk);
        rstn = 1'b1;
        cyc(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0);
        chk("midrst_cnt", dut.cnt, 32'd0);
        cyc(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, D2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
